// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kyber_pkg
//  Description : Shared Kyber constants, FSM state type and the twiddle
//                factor (zeta) table in signed Montgomery form. The table is
//                shared by the NTT, basemul and zeta-multiply stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package kyber_pkg;

    localparam int KYBER_Q  = 3329;
    localparam int KYBER_N  = 256;
    localparam int ZETA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int PROD_W   = 32;
    localparam int ZETA_CNT = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stage_state_e;

    // zetas[i] = mont * root^brv7(i) mod q, centred in (-q/2, q/2)
    localparam int ZETAS [ZETA_CNT] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    // Table lookup narrowed to the zeta datapath width.
    function automatic logic signed [ZETA_W-1:0] zeta_at(input int unsigned idx);
        return ZETA_W'(ZETAS[idx]);
    endfunction

endpackage : kyber_pkg
`default_nettype wire

// File: rtl/zeta_rom.sv
`default_nettype none
// ============================================================================
//  Module      : zeta_rom
//  Description : Synchronous-read zeta ROM. The output register only updates
//                while en_i is high so it can sit inside a stallable pipe
//                stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module zeta_rom
    import kyber_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic signed [ZETA_W-1:0] data_o
);

    logic signed [ZETA_W-1:0] data_q;

    // Registered table read; holds its value while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= zeta_at(int'(addr_i));
        end
    end

    assign data_o = data_q;

endmodule : zeta_rom
`default_nettype wire

// File: rtl/zeta_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : zeta_mul_stage
//  Description : Burst-oriented coefficient x zeta multiplier feeding
//                montgomery_reduce. Two-stage pipeline: S1 holds the coef and
//                the ROM zeta, S2 holds the full signed 32-bit product. The
//                zeta index advances every GROUP accepted coefficients.
//  Revision    : 1.0 - initial release
// ============================================================================
module zeta_mul_stage
    import kyber_pkg::*;
#(
    parameter int GROUP  = 2,
    parameter int N_ZETA = 128,
    parameter int LEN_W  = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(N_ZETA)-1:0]    idx_start,
    input  logic [LEN_W-1:0]             len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [COEF_W-1:0]     coef,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [PROD_W-1:0]     prod,
    output logic                         set,
    output logic                         last,
    output logic [$clog2(N_ZETA)-1:0]    zeta_idx,
    output logic                         busy
);

    // Index width equals log2(N_ZETA); the natural binary wrap of the index
    // register implements the 127 -> 0 wrap, so N_ZETA must be a power of 2.
    localparam int IDX_W = $clog2(N_ZETA);
    localparam int GC_W  = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [GC_W-1:0] GROUP_LAST = GC_W'(GROUP - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    stage_state_e       state_q,     state_d;
    logic [IDX_W-1:0]   zeta_idx_q,  zeta_idx_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [GC_W-1:0]    group_cnt_q, group_cnt_d;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                       s1_valid_q;
    logic                       s1_last_q;
    logic signed [COEF_W-1:0]   s1_coef_q;
    logic                       s2_valid_q;
    logic                       s2_last_q;
    logic signed [PROD_W-1:0]   s2_prod_q;

    logic                       adv;
    logic                       accept;
    logic signed [ZETA_W-1:0]   rom_zeta;
    logic signed [PROD_W-1:0]   prod_d;

    // The whole pipe moves together whenever S2 is empty or being drained.
    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = (state_q == ST_RUN) && (remaining_q != '0) && adv;
    assign accept   = in_valid && in_ready;

    // The ROM output register is the zeta half of S1: it samples the index
    // in the same cycle S1 samples the coefficient.
    zeta_rom #(
        .ADDR_W (IDX_W)
    ) u_zeta_rom (
        .clk    (clk),
        .en_i   (adv),
        .addr_i (zeta_idx_q),
        .data_o (rom_zeta)
    );

    // Full-precision signed product; operands are sign-extended first.
    assign prod_d = PROD_W'(s1_coef_q) * PROD_W'(rom_zeta);

    // Control registers: state, zeta index, remaining count, group counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            zeta_idx_q  <= '0;
            remaining_q <= '0;
            group_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            zeta_idx_q  <= zeta_idx_d;
            remaining_q <= remaining_d;
            group_cnt_q <= group_cnt_d;
        end
    end

    // Next-state logic for burst sequencing and zeta index advance.
    always_comb begin
        state_d     = state_q;
        zeta_idx_d  = zeta_idx_q;
        remaining_d = remaining_q;
        group_cnt_d = group_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_d     = ST_RUN;
                    zeta_idx_d  = idx_start;
                    remaining_d = len;
                    group_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (group_cnt_q == GROUP_LAST) begin
                        group_cnt_d = '0;
                        zeta_idx_d  = zeta_idx_q + IDX_W'(1);
                    end else begin
                        group_cnt_d = group_cnt_q + GC_W'(1);
                    end
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-stage datapath; everything holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_coef_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && (remaining_q == LEN_W'(1));
            s1_coef_q  <= coef;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign prod      = s2_prod_q;
    assign last      = s2_last_q;
    assign set       = s2_valid_q && out_ready;
    assign zeta_idx  = zeta_idx_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : zeta_mul_stage
`default_nettype wire
